// File: rtl/biriscv_issue_sched.sv
// In-order dual-issue scheduler: hazard scoreboard for multi-cycle results,
// divider occupancy tracking and FIFO pop (accept) generation for two slots.
module biriscv_issue_sched #(
  parameter int SUPPORT_DUAL_ISSUE = 1,
  parameter int LOAD_LATENCY       = 2,
  parameter int MUL_LATENCY        = 2,
  parameter int DIV_LATENCY        = 34
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        slot0_valid_i,
  input  logic [31:0] slot0_instr_i,
  input  logic        slot0_exec_i,
  input  logic        slot0_lsu_i,
  input  logic        slot0_branch_i,
  input  logic        slot0_mul_i,
  input  logic        slot0_div_i,
  input  logic        slot0_csr_i,
  input  logic        slot0_rd_valid_i,
  input  logic        slot0_invalid_i,
  input  logic        slot1_valid_i,
  input  logic [31:0] slot1_instr_i,
  input  logic        slot1_exec_i,
  input  logic        slot1_lsu_i,
  input  logic        slot1_branch_i,
  input  logic        slot1_mul_i,
  input  logic        slot1_div_i,
  input  logic        slot1_csr_i,
  input  logic        slot1_rd_valid_i,
  input  logic        slot1_invalid_i,
  output logic        slot0_accept_o,
  output logic        slot1_accept_o,
  output logic        div_busy_o,
  output logic [31:0] dual_issue_cnt_o
);

  localparam logic DUAL_EN = (SUPPORT_DUAL_ISSUE != 0);

  // Result latency for a long op; div dominates mul dominates load.
  function automatic logic [5:0] op_latency(input logic mul, input logic div);
    if (div)      return 6'(DIV_LATENCY);
    else if (mul) return 6'(MUL_LATENCY);
    else          return 6'(LOAD_LATENCY);
  endfunction

  logic [5:0]  sb_q [32];
  logic [5:0]  div_cnt_q;
  logic [31:0] busy;
  logic [4:0]  rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
  logic        hz0, hz1, pair_ok, set0, set1;
  logic [5:0]  lat0, lat1;

  // Single-cycle exec flag and non-register instruction bits carry no scheduling info.
  logic unused_bits;
  assign unused_bits = ^{slot0_instr_i[31:25], slot0_instr_i[14:12], slot0_instr_i[6:0],
                         slot1_instr_i[31:25], slot1_instr_i[14:12], slot1_instr_i[6:0],
                         slot0_exec_i, slot1_exec_i, slot1_branch_i};

  assign rd0   = slot0_instr_i[11:7];
  assign rs1_0 = slot0_instr_i[19:15];
  assign rs2_0 = slot0_instr_i[24:20];
  assign rd1   = slot1_instr_i[11:7];
  assign rs1_1 = slot1_instr_i[19:15];
  assign rs2_1 = slot1_instr_i[24:20];

  assign div_busy_o = (div_cnt_q != 6'd0);

  // Hazard detection, pair legality and accept generation.
  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (sb_q[r] != 6'd0);

    hz0 = busy[rs1_0] | busy[rs2_0] | (slot0_rd_valid_i & busy[rd0]);
    hz1 = busy[rs1_1] | busy[rs2_1] | (slot1_rd_valid_i & busy[rd1]);

    pair_ok = ~(slot0_lsu_i & slot1_lsu_i)
            & ~((slot0_mul_i | slot0_div_i) & (slot1_mul_i | slot1_div_i))
            & ~slot0_csr_i & ~slot1_csr_i & ~slot0_invalid_i & ~slot1_invalid_i
            & ~slot0_branch_i
            & ~(slot0_rd_valid_i & (rd0 != 5'd0) & ((rs1_1 == rd0) | (rs2_1 == rd0)))
            & ~(slot0_rd_valid_i & slot1_rd_valid_i & (rd0 == rd1));

    slot0_accept_o = rst_ni & slot0_valid_i & ~flush_i
                   & (slot0_invalid_i | ~hz0) & ~(slot0_div_i & div_busy_o);

    slot1_accept_o = rst_ni & slot1_valid_i & ~flush_i
                   & (slot1_invalid_i | ~hz1) & ~(slot1_div_i & div_busy_o)
                   & (~slot0_valid_i | (DUAL_EN & slot0_accept_o & pair_ok));

    set0 = slot0_accept_o & slot0_rd_valid_i & (rd0 != 5'd0)
         & (slot0_lsu_i | slot0_mul_i | slot0_div_i);
    set1 = slot1_accept_o & slot1_rd_valid_i & (rd1 != 5'd0)
         & (slot1_lsu_i | slot1_mul_i | slot1_div_i);
    lat0 = op_latency(slot0_mul_i, slot0_div_i);
    lat1 = op_latency(slot1_mul_i, slot1_div_i);
  end

  // Scoreboard: load latency on long-op issue, otherwise count down to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) sb_q[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (set0 && rd0 == 5'(r))       sb_q[r] <= lat0;
        else if (set1 && rd1 == 5'(r))  sb_q[r] <= lat1;
        else if (sb_q[r] != 6'd0)       sb_q[r] <= sb_q[r] - 6'd1;
      end
    end
  end

  // Divider occupancy window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      div_cnt_q <= '0;
    else if ((slot0_accept_o & slot0_div_i) | (slot1_accept_o & slot1_div_i))
      div_cnt_q <= 6'(DIV_LATENCY);
    else if (div_cnt_q != 6'd0)
      div_cnt_q <= div_cnt_q - 6'd1;
  end

  // Dual-issue cycle counter (free-running, wraps).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      dual_issue_cnt_o <= '0;
    else if (slot0_accept_o & slot1_accept_o)
      dual_issue_cnt_o <= dual_issue_cnt_o + 32'd1;
  end

endmodule

// File: tb/tb_biriscv_issue_sched.sv
// Testbench for biriscv_issue_sched: directed scenarios plus randomized traffic
// checked against a ready-time based reference model.
module tb_biriscv_issue_sched;

  localparam int LOAD_LAT = 2;
  localparam int MUL_LAT  = 2;
  localparam int DIV_LAT  = 34;

  localparam int C_EXEC = 0, C_LSU = 1, C_MUL = 2, C_DIV = 3, C_BR = 4, C_CSR = 5, C_INV = 6;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic        exec, lsu, br, mul, div, csr, rdv, inv;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  slot_t       s0 = '0;
  slot_t       s1 = '0;
  logic        acc0, acc1, div_busy;
  logic [31:0] dual_cnt;

  always #5 clk = ~clk;

  biriscv_issue_sched #(
    .SUPPORT_DUAL_ISSUE(1), .LOAD_LATENCY(LOAD_LAT), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .slot0_valid_i(s0.v), .slot0_instr_i(s0.instr), .slot0_exec_i(s0.exec),
    .slot0_lsu_i(s0.lsu), .slot0_branch_i(s0.br), .slot0_mul_i(s0.mul),
    .slot0_div_i(s0.div), .slot0_csr_i(s0.csr), .slot0_rd_valid_i(s0.rdv),
    .slot0_invalid_i(s0.inv),
    .slot1_valid_i(s1.v), .slot1_instr_i(s1.instr), .slot1_exec_i(s1.exec),
    .slot1_lsu_i(s1.lsu), .slot1_branch_i(s1.br), .slot1_mul_i(s1.mul),
    .slot1_div_i(s1.div), .slot1_csr_i(s1.csr), .slot1_rd_valid_i(s1.rdv),
    .slot1_invalid_i(s1.inv),
    .slot0_accept_o(acc0), .slot1_accept_o(acc1),
    .div_busy_o(div_busy), .dual_issue_cnt_o(dual_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a register is pending until a ready cycle; divider free at a cycle.
  int          now = 0;
  int          ready_at [32];
  int          div_free = 0;
  int unsigned m_dual = 0;
  logic        obs0, obs1;

  function automatic slot_t mk(input int cls, input int rd, input int rs1, input int rs2);
    slot_t s;
    s = '0;
    s.v     = 1'b1;
    s.instr = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    s.exec  = (cls == C_EXEC);
    s.lsu   = (cls == C_LSU);
    s.mul   = (cls == C_MUL);
    s.div   = (cls == C_DIV);
    s.br    = (cls == C_BR);
    s.csr   = (cls == C_CSR);
    s.inv   = (cls == C_INV);
    s.rdv   = (cls == C_EXEC) || (cls == C_LSU) || (cls == C_MUL) || (cls == C_DIV) || (cls == C_CSR);
    return s;
  endfunction

  function automatic bit pending(input logic [4:0] r);
    return (r != 5'd0) && (now < ready_at[r]);
  endfunction

  function automatic bit blocked_by_reg(input slot_t s);
    return pending(s.instr[19:15]) || pending(s.instr[24:20]) || (s.rdv && pending(s.instr[11:7]));
  endfunction

  function automatic bit can_pair(input slot_t a, input slot_t b);
    logic [4:0] ard;
    ard = a.instr[11:7];
    if (a.lsu && b.lsu) return 0;
    if ((a.mul || a.div) && (b.mul || b.div)) return 0;
    if (a.csr || b.csr || a.inv || b.inv || a.br) return 0;
    if (a.rdv && ard != 0 && (b.instr[19:15] == ard || b.instr[24:20] == ard)) return 0;
    if (a.rdv && b.rdv && ard == b.instr[11:7]) return 0;
    return 1;
  endfunction

  task automatic retire_model(input slot_t s);
    int lat;
    lat = s.div ? DIV_LAT : (s.mul ? MUL_LAT : LOAD_LAT);
    if (s.rdv && s.instr[11:7] != 0 && (s.lsu || s.mul || s.div))
      ready_at[s.instr[11:7]] = now + lat + 1;
    if (s.div) div_free = now + DIV_LAT + 1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    div_free = 0;
    m_dual   = 0;
    now      = 0;
  endtask

  // One scheduling cycle: drive, compare against model, advance model on the edge.
  task automatic cycle(input slot_t a, input slot_t b, input logic fl);
    bit dbusy, e0, e1;
    @(negedge clk);
    s0 = a; s1 = b; flush = fl;
    #1;
    dbusy = (now < div_free);
    e0 = a.v && !fl && (a.inv || !blocked_by_reg(a)) && !(a.div && dbusy);
    e1 = b.v && !fl && (b.inv || !blocked_by_reg(b)) && !(b.div && dbusy)
         && (!a.v || (e0 && can_pair(a, b)));
    check("acc0", {31'd0, acc0}, {31'd0, e0});
    check("acc1", {31'd0, acc1}, {31'd0, e1});
    check("div_busy", {31'd0, div_busy}, {31'd0, dbusy});
    check("dual_cnt", dual_cnt, m_dual);
    obs0 = acc0; obs1 = acc1;
    @(posedge clk);
    if (e0) retire_model(a);
    if (e1) retire_model(b);
    if (e0 && e1) m_dual++;
    now++;
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    s0 = mk(C_EXEC, 1, 0, 0); s1 = mk(C_EXEC, 2, 0, 0); flush = 1'b0;
    #1;
    check("rst_acc0", {31'd0, acc0}, 32'd0);
    check("rst_acc1", {31'd0, acc1}, 32'd0);
    check("rst_div_busy", {31'd0, div_busy}, 32'd0);
    check("rst_dual_cnt", dual_cnt, 32'd0);
    clear_model();
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    s0 = '0; s1 = '0;
    rst_n = 1'b1;
  endtask

  slot_t idle;
  int    blocked;

  function automatic slot_t rnd_slot();
    int p, cls;
    slot_t s;
    p = int'($urandom_range(0, 99));
    if (p < 45) cls = C_EXEC; else if (p < 60) cls = C_LSU; else if (p < 70) cls = C_MUL;
    else if (p < 74) cls = C_DIV; else if (p < 84) cls = C_BR; else if (p < 90) cls = C_CSR;
    else cls = C_INV;
    s = mk(cls, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    s.v = ($urandom_range(0, 9) < 8);
    return s;
  endfunction

  initial begin
    idle = '0;
    clear_model();
    do_reset(3);

    // Two independent ADDs issue together.
    cycle(mk(C_EXEC, 1, 0, 0), mk(C_EXEC, 2, 0, 0), 1'b0);
    check("pair_acc0", {31'd0, obs0}, 32'd1);
    check("pair_acc1", {31'd0, obs1}, 32'd1);
    #1 check("pair_dual_cnt", dual_cnt, 32'd1);

    // RAW inside the pair: slot1 waits, then goes alone.
    cycle(mk(C_EXEC, 5, 1, 2), mk(C_EXEC, 6, 5, 0), 1'b0);
    check("raw_acc0", {31'd0, obs0}, 32'd1);
    check("raw_acc1", {31'd0, obs1}, 32'd0);
    cycle(idle, mk(C_EXEC, 6, 5, 0), 1'b0);
    check("raw_late_acc1", {31'd0, obs1}, 32'd1);

    // Load-use stall.
    cycle(mk(C_LSU, 3, 0, 0), idle, 1'b0);
    blocked = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(mk(C_EXEC, 9, 3, 0), idle, 1'b0);
      if (obs0) break;
      blocked++;
    end
    check("load_use_blocked", 32'(blocked), 32'(LOAD_LAT));

    // Divider occupancy.
    cycle(mk(C_DIV, 4, 0, 0), idle, 1'b0);
    blocked = 0;
    for (int k = 0; k < 100; k++) begin
      cycle(mk(C_DIV, 6, 0, 0), idle, 1'b0);
      if (obs0) break;
      blocked++;
    end
    check("div_blocked", 32'(blocked), 32'(DIV_LAT));

    // Flush holds both slots while a pending load keeps counting.
    cycle(mk(C_LSU, 7, 0, 0), idle, 1'b0);
    cycle(mk(C_EXEC, 1, 0, 0), mk(C_EXEC, 2, 0, 0), 1'b1);
    check("flush_acc0", {31'd0, obs0}, 32'd0);
    check("flush_acc1", {31'd0, obs1}, 32'd0);
    blocked = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(mk(C_EXEC, 9, 7, 0), idle, 1'b0);
      if (obs0) break;
      blocked++;
    end
    check("flush_load_blocked", 32'(blocked), 32'(LOAD_LAT - 1));

    // Reset while the divider is busy clears everything.
    cycle(idle, idle, 1'b0);
    do_reset(2);
    cycle(mk(C_EXEC, 11, 6, 0), mk(C_DIV, 10, 0, 0), 1'b0);
    check("post_rst_acc0", {31'd0, obs0}, 32'd1);
    check("post_rst_acc1", {31'd0, obs1}, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if (n % 1500 == 1499) do_reset(1);
      cycle(rnd_slot(), rnd_slot(), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
